// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter and two-stage issue/response sequencer for the shared ALU
module alu_share_arb #(
    parameter int              W       = 32,
    parameter int              SELW    = 4,
    parameter logic [SELW-1:0] ALU_ADD = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [SELW-1:0] req0_sel,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic [SELW-1:0] req1_sel,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [SELW-1:0] alu_sel,
    input  logic [W-1:0]    alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_zero
);

    logic            r_s1_valid;
    logic            r_s1_id;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [SELW-1:0] r_alu_sel;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [W-1:0]    r_rsp_data;
    logic            r_rsp_zero;
    logic            r_last_id;

    logic w_stall;
    logic w_grant0;
    logic w_grant1;
    logic w_acc0;
    logic w_acc1;

    // A held response freezes the whole pipe so the ALU inputs, and thus its output, stay put.
    assign w_stall  = r_rsp_valid & ~rsp_ready;
    assign w_grant0 = req0_valid & (~req1_valid | r_last_id);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_id);

    assign req0_ready = w_grant0 & ~w_stall;
    assign req1_ready = w_grant1 & ~w_stall;
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_id     <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= ALU_ADD;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_last_id   <= 1'b1;
        end else if (!w_stall) begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_data <= alu_result;
                r_rsp_zero <= alu_zero;
                r_rsp_id   <= r_s1_id;
            end
            r_s1_valid <= w_acc0 | w_acc1;
            if (w_acc0) begin
                r_alu_a   <= req0_a;
                r_alu_b   <= req0_b;
                r_alu_sel <= req0_sel;
                r_s1_id   <= 1'b0;
                r_last_id <= 1'b0;
            end else if (w_acc1) begin
                r_alu_a   <= req1_a;
                r_alu_b   <= req1_b;
                r_alu_sel <= req1_sel;
                r_s1_id   <= 1'b1;
                r_last_id <= 1'b1;
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed vector table, reset corner and random stress for alu_share_arb
module tb_alu_share_arb;

    localparam logic [3:0] ADD  = 4'h0;
    localparam logic [3:0] SUB  = 4'h1;
    localparam logic [3:0] PASS = 4'hA;
    localparam logic [3:0] UNK  = 4'hD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_sel = '0, req1_sel = '0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_id, rsp_zero;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.W(32), .SELW(4), .ALU_ADD(ADD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        case (s)
            ADD:     return a + b;
            SUB:     return a - b;
            PASS:    return a;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_sel);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: one slot for the op at the ALU, one for the pending response.
    logic        m_s1v, m_s1id, m_s1z, m_s2v, m_s2id, m_s2z, m_last, m_stall, m_g0, m_g1;
    logic [31:0] m_s1d, m_s2d, m_res;
    logic        acc0, acc1;
    int          n_acc, n_rsp;
    logic        mon_en = 1'b1;

    always @(negedge clk) begin
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (!rst_n) begin
            m_s1v = 1'b0; m_s2v = 1'b0; m_last = 1'b1;
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end else if (mon_en) begin
            m_stall = m_s2v & ~rsp_ready;
            m_g0 = !m_stall && req0_valid && (!req1_valid || m_last);
            m_g1 = !m_stall && req1_valid && (!req0_valid || !m_last);
            chk("mon_ready0", {31'd0, req0_ready}, {31'd0, m_g0});
            chk("mon_ready1", {31'd0, req1_ready}, {31'd0, m_g1});
            chk("mon_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_s2v});
            if (m_s2v) begin
                chk("mon_rsp_id", {31'd0, rsp_id}, {31'd0, m_s2id});
                chk("mon_rsp_data", rsp_data, m_s2d);
                chk("mon_rsp_zero", {31'd0, rsp_zero}, {31'd0, m_s2z});
                if (rsp_ready) n_rsp++;
            end
            if (!m_stall) begin
                m_s2v = m_s1v; m_s2id = m_s1id; m_s2d = m_s1d; m_s2z = m_s1z;
                m_s1v = m_g0 | m_g1;
                if (m_g0) begin
                    m_res = alu_f(req0_a, req0_b, req0_sel);
                    m_s1id = 1'b0; m_last = 1'b0;
                end else begin
                    m_res = alu_f(req1_a, req1_b, req1_sel);
                    m_s1id = 1'b1; if (m_g1) m_last = 1'b1;
                end
                m_s1d = m_res; m_s1z = (m_res == 32'd0);
                if (m_g0 | m_g1) n_acc++;
            end
        end
    end

    typedef struct {
        logic v0; logic [31:0] a0, b0; logic [3:0] s0;
        logic v1; logic [31:0] a1, b1; logic [3:0] s1;
        logic rr;
        logic e_r0, e_r1, e_rv, e_id; logic [31:0] e_d; logic e_z;
        logic e_sc; logic [3:0] e_sel;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] s0,
                                input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] s1,
                                input logic rr, input logic e_r0, input logic e_r1, input logic e_rv, input logic e_id,
                                input logic [31:0] e_d, input logic e_z, input logic e_sc, input logic [3:0] e_sel);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.s0 = s0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.s1 = s1;
        v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv; v.e_id = e_id;
        v.e_d = e_d; v.e_z = e_z; v.e_sc = e_sc; v.e_sel = e_sel;
        return v;
    endfunction

    vec_t tbl[26];

    task automatic apply(input vec_t v);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_sel = v.s0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_sel = v.s1;
        rsp_ready = v.rr;
    endtask

    task automatic idle(input logic rr);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = rr;
    endtask

    initial begin
        tbl[0]  = mk(1, 7, 7, SUB, 1, 1, 1, ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 7, 7, SUB, 1, 1, 1, ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 7, 7, SUB, 1, 1, 1, ADD, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        tbl[3]  = mk(1, 7, 7, SUB, 1, 1, 1, ADD, 1, 0, 1, 1, 1, 2, 0, 0, 0);
        tbl[4]  = mk(1, 7, 7, SUB, 1, 1, 1, ADD, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(1, 7, 7, SUB, 1, 1, 1, ADD, 1, 0, 1, 1, 1, 2, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 1, 2, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 5, 3, ADD, 0, 0, 0, ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 0, 8, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, ADD, 1, 10, 1, ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, ADD, 1, 20, 2, ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, ADD, 1, 30, 3, ADD, 0, 0, 0, 1, 1, 11, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, ADD, 1, 30, 3, ADD, 0, 0, 0, 1, 1, 11, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, ADD, 1, 30, 3, ADD, 0, 0, 0, 1, 1, 11, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, ADD, 1, 30, 3, ADD, 1, 0, 1, 1, 1, 11, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 1, 22, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 1, 33, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 32'h1234, 9, PASS, 0, 0, 0, ADD, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, ADD, 1, 32'hF0, 32'h0F, UNK, 1, 0, 1, 0, 0, 0, 0, 1, PASS);
        tbl[23] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 0, 32'h1234, 0, 1, UNK);
        tbl[24] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 1, 1, 32'hFF, 0, 0, 0);
        tbl[25] = mk(0, 0, 0, ADD, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_b", alu_b, 32'd0);
        chk("reset_alu_sel", {28'd0, alu_sel}, {28'd0, ADD});
        @(posedge clk); #2 rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1 apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, tbl[i].e_r0});
            chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, tbl[i].e_r1});
            chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].e_rv});
            if (tbl[i].e_rv) begin
                chk($sformatf("v%0d_rsp_id", i), {31'd0, rsp_id}, {31'd0, tbl[i].e_id});
                chk($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].e_d);
                chk($sformatf("v%0d_rsp_zero", i), {31'd0, rsp_zero}, {31'd0, tbl[i].e_z});
            end
            if (tbl[i].e_sc) chk($sformatf("v%0d_alu_sel", i), {28'd0, alu_sel}, {28'd0, tbl[i].e_sel});
        end

        // Asynchronous reset with both stages occupied
        @(posedge clk); #1 idle(1'b1); req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_sel = ADD;
        @(posedge clk); #1 idle(1'b1); req1_valid = 1'b1; req1_a = 2; req1_b = 2; req1_sel = ADD;
        @(posedge clk); #1 idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_alu_sel", {28'd0, alu_sel}, {28'd0, ADD});
        @(posedge clk); #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 9; req0_b = 4; req0_sel = SUB;
        req1_valid = 1'b1; req1_a = 3; req1_b = 3; req1_sel = ADD;
        @(negedge clk);
        chk("arst_next_ready0", {31'd0, req0_ready}, 32'd1);
        chk("arst_next_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1 idle(1'b1);
        @(negedge clk);
        chk("arst_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("arst_new_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("arst_new_rsp_data", rsp_data, 32'd5);
        repeat (3) @(negedge clk);

        // Random stress; held requests keep their operands until accepted
        @(posedge clk); #1 n_acc = 0; n_rsp = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!req0_valid || acc0) begin
                req0_valid = $urandom_range(0, 1);
                req0_a = $urandom_range(0, 15); req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
                req0_sel = ($urandom_range(0, 3) == 3) ? 4'($urandom) : 4'($urandom_range(0, 1));
            end
            if (!req1_valid || acc1) begin
                req1_valid = $urandom_range(0, 1);
                req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
                req1_sel = ($urandom_range(0, 3) == 3) ? PASS : 4'($urandom_range(0, 1));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 idle(1'b1);
        repeat (5) @(negedge clk);
        chk("stress_acc_eq_rsp", n_rsp, n_acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
